// File: rtl/bcd_count_ctrl.sv
// -----------------------------------------------------------------------------
// bcd_count_ctrl
//
// Run/pause/clear controller and display scheduler for a 4-digit BCD counter.
// A single-cycle count-enable pulse is made from clkFPGA by a prescaler, so
// the whole design stays in one clock domain. The count steps up or down
// through 0000..9999. The digits are time-multiplexed onto one BCD output,
// with an active-low one-hot digit enable.
//
// Parameters
//   TICK_DIV  clock cycles per count step (>= 2)
//   SCAN_DIV  clock cycles per digit-scan slot (>= 2)
//
// Ports
//   clkFPGA       in   1   system clock, rising edge
//   rst_n         in   1   synchronous active-low reset
//   btnStartStop  in   1   start/pause/resume pulse (synchronised, debounced)
//   btnClear      in   1   clear pulse (synchronised, debounced); wins over all
//   up            in   1   count direction, 1 = up, 0 = down
//   digits        out  16  registered BCD count {d3,d2,d1,d0}
//   running       out  1   high while the controller is in RUN
//   tick          out  1   one-cycle pulse with the first cycle of a new count
//   carry         out  1   one-cycle pulse on wrap, coincident with tick
//   an            out  4   active-low one-hot digit enable
//   bcdOut        out  4   BCD value of the digit selected by an
// -----------------------------------------------------------------------------
module bcd_count_ctrl #(
    parameter int TICK_DIV = 5000000,
    parameter int SCAN_DIV = 50000
) (
    input  logic        clkFPGA,
    input  logic        rst_n,
    input  logic        btnStartStop,
    input  logic        btnClear,
    input  logic        up,
    output logic [15:0] digits,
    output logic        running,
    output logic        tick,
    output logic        carry,
    output logic [3:0]  an,
    output logic [3:0]  bcdOut
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int SW = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // BCD arithmetic helpers
    // -------------------------------------------------------------------------

    // One digit plus carry-in. Returns {carry_out, digit}. An out-of-range
    // digit is forced back to 0 so the count can never leave 0..9.
    function automatic logic [4:0] digit_inc(input logic [3:0] d, input logic cin);
        logic [4:0] res;
        if (d > 4'd9) begin
            res = {1'b0, 4'd0};
        end else if (!cin) begin
            res = {1'b0, d};
        end else if (d == 4'd9) begin
            res = {1'b1, 4'd0};
        end else begin
            res = {1'b0, d + 4'd1};
        end
        return res;
    endfunction

    // One digit minus borrow-in. Returns {borrow_out, digit}. An out-of-range
    // digit is forced to 9 so the count can never leave 0..9.
    function automatic logic [4:0] digit_dec(input logic [3:0] d, input logic bin);
        logic [4:0] res;
        if (d > 4'd9) begin
            res = {1'b0, 4'd9};
        end else if (!bin) begin
            res = {1'b0, d};
        end else if (d == 4'd0) begin
            res = {1'b1, 4'd9};
        end else begin
            res = {1'b0, d - 4'd1};
        end
        return res;
    endfunction

    // Full 4-digit step. Returns {wrap, new_count}; wrap is the carry/borrow
    // out of the most significant digit (9999->0000 or 0000->9999).
    function automatic logic [16:0] count_step(input logic [15:0] cnt, input logic up_dir);
        logic [15:0] nxt;
        logic        chain;
        logic [4:0]  dig;
        nxt   = 16'h0000;
        chain = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (up_dir) begin
                dig = digit_inc(cnt[4*i +: 4], chain);
            end else begin
                dig = digit_dec(cnt[4*i +: 4], chain);
            end
            nxt[4*i +: 4] = dig[3:0];
            chain         = dig[4];
        end
        return {chain, nxt};
    endfunction

    // -------------------------------------------------------------------------
    // Registers and wires
    // -------------------------------------------------------------------------
    state_t          r_state;
    state_t          w_state_nxt;
    logic [PW-1:0]   r_presc;
    logic [PW-1:0]   w_presc_nxt;
    logic [15:0]     r_digits;
    logic [15:0]     w_digits_nxt;
    logic            r_running;
    logic            r_tick;
    logic            r_carry;
    logic [SW-1:0]   r_scan_cnt;
    logic [1:0]      r_scan_idx;
    logic            w_terminal;
    logic            w_scan_last;
    logic [16:0]     w_step;
    logic [3:0]      w_bcd_sel;

    // A step is due on the last prescaler count in RUN; a same-cycle clear
    // suppresses it. btnStartStop does not, so a pause on the terminal cycle
    // still lands the step.
    assign w_terminal  = (r_state == ST_RUN) && (r_presc == PRESC_LAST) && !btnClear;
    assign w_step      = count_step(r_digits, up);
    assign w_scan_last = (r_scan_cnt == SCAN_LAST);

    // Next-state logic: clear dominates, otherwise start/stop toggles RUN.
    always_comb begin
        w_state_nxt = r_state;
        if (btnClear) begin
            w_state_nxt = ST_IDLE;
        end else if (btnStartStop) begin
            case (r_state)
                ST_IDLE:  w_state_nxt = ST_RUN;
                ST_RUN:   w_state_nxt = ST_PAUSE;
                ST_PAUSE: w_state_nxt = ST_RUN;
                default:  w_state_nxt = ST_IDLE;
            endcase
        end else begin
            w_state_nxt = r_state;
        end
    end

    // Prescaler next value: counts in RUN, frozen in PAUSE so a resume
    // continues the interval, held at zero in IDLE so a start begins afresh.
    always_comb begin
        w_presc_nxt = r_presc;
        if (btnClear) begin
            w_presc_nxt = '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_terminal) begin
                        w_presc_nxt = '0;
                    end else begin
                        w_presc_nxt = r_presc + PW'(1);
                    end
                end
                ST_PAUSE: w_presc_nxt = r_presc;
                ST_IDLE:  w_presc_nxt = '0;
                default:  w_presc_nxt = '0;
            endcase
        end
    end

    // Count next value: zero on clear or in IDLE, stepped on terminal.
    always_comb begin
        w_digits_nxt = r_digits;
        if (btnClear) begin
            w_digits_nxt = 16'h0000;
        end else if (w_terminal) begin
            w_digits_nxt = w_step[15:0];
        end else if (r_state == ST_IDLE) begin
            w_digits_nxt = 16'h0000;
        end else begin
            w_digits_nxt = r_digits;
        end
    end

    // Controller registers: state, prescaler, count and the status pulses.
    always_ff @(posedge clkFPGA) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_presc   <= '0;
            r_digits  <= 16'h0000;
            r_running <= 1'b0;
            r_tick    <= 1'b0;
            r_carry   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_presc   <= w_presc_nxt;
            r_digits  <= w_digits_nxt;
            r_running <= (w_state_nxt == ST_RUN);
            r_tick    <= w_terminal;
            r_carry   <= w_terminal && w_step[16];
        end
    end

    // Scan scheduler: free-running in every state, unaffected by clear.
    always_ff @(posedge clkFPGA) begin
        if (!rst_n) begin
            r_scan_cnt <= '0;
            r_scan_idx <= 2'd0;
        end else if (w_scan_last) begin
            r_scan_cnt <= '0;
            r_scan_idx <= r_scan_idx + 2'd1;
        end else begin
            r_scan_cnt <= r_scan_cnt + SW'(1);
            r_scan_idx <= r_scan_idx;
        end
    end

    // Digit multiplexer: follows the registered count in the same cycle.
    always_comb begin
        w_bcd_sel = 4'd0;
        case (r_scan_idx)
            2'd0:    w_bcd_sel = r_digits[3:0];
            2'd1:    w_bcd_sel = r_digits[7:4];
            2'd2:    w_bcd_sel = r_digits[11:8];
            2'd3:    w_bcd_sel = r_digits[15:12];
            default: w_bcd_sel = 4'd0;
        endcase
    end

    assign digits  = r_digits;
    assign running = r_running;
    assign tick    = r_tick;
    assign carry   = r_carry;
    assign an      = ~(4'b0001 << r_scan_idx);
    assign bcdOut  = w_bcd_sel;

endmodule

// File: tb/tb_bcd_count_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for bcd_count_ctrl (TICK_DIV = 4, SCAN_DIV = 3).
// A vector table covers reset and start. Hand-written sequences cover wrap,
// borrow, pause/resume, clear priority and scan. A randomized phase follows.
// An integer-arithmetic reference model checks every cycle.
// -----------------------------------------------------------------------------
module tb_bcd_count_ctrl;

    localparam int TD = 4;
    localparam int SD = 3;

    logic        clkFPGA = 1'b0;
    logic        rst_n = 1'b0;
    logic        btnStartStop = 1'b0;
    logic        btnClear = 1'b0;
    logic        up = 1'b1;
    logic [15:0] digits;
    logic        running;
    logic        tick;
    logic        carry;
    logic [3:0]  an;
    logic [3:0]  bcdOut;

    bcd_count_ctrl #(.TICK_DIV(TD), .SCAN_DIV(SD)) dut (
        .clkFPGA      (clkFPGA),
        .rst_n        (rst_n),
        .btnStartStop (btnStartStop),
        .btnClear     (btnClear),
        .up           (up),
        .digits       (digits),
        .running      (running),
        .tick         (tick),
        .carry        (carry),
        .an           (an),
        .bcdOut       (bcdOut)
    );

    always #5 clkFPGA = ~clkFPGA;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: 0 = idle, 1 = run, 2 = pause; count is a plain integer.
    int m_state = 0;
    int m_presc = 0;
    int m_count = 0;
    int m_sidx  = 0;
    int m_scnt  = 0;
    bit m_tick  = 1'b0;
    bit m_carry = 1'b0;
    int pw10[4];

    typedef struct {
        bit          rst;
        bit          ss;
        bit          clr;
        bit          upd;
        logic [15:0] d;
        bit          run;
        bit          tk;
        bit          cy;
        logic [3:0]  an_e;
    } vec_t;
    vec_t tbl[11];

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int          x;
        x = v;
        r = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input bit ss, input bit clr, input bit upv, input bit rstv);
        bit term;
        if (!rstv) begin
            m_state = 0; m_presc = 0; m_count = 0;
            m_sidx = 0;  m_scnt = 0;
            m_tick = 1'b0; m_carry = 1'b0;
        end else begin
            term    = (m_state == 1) && (m_presc == TD - 1) && !clr;
            m_tick  = term;
            m_carry = 1'b0;
            if (clr) begin
                m_state = 0; m_count = 0; m_presc = 0;
            end else begin
                if (m_state == 1) begin
                    if (term) begin
                        m_presc = 0;
                        if (upv) begin
                            m_carry = (m_count == 9999);
                            m_count = (m_count + 1) % 10000;
                        end else begin
                            m_carry = (m_count == 0);
                            m_count = (m_count + 9999) % 10000;
                        end
                    end else begin
                        m_presc = m_presc + 1;
                    end
                end
                if (ss) m_state = (m_state == 1) ? 2 : 1;
            end
            if (m_scnt == SD - 1) begin
                m_scnt = 0;
                m_sidx = (m_sidx + 1) % 4;
            end else begin
                m_scnt = m_scnt + 1;
            end
        end
    endtask

    // One clock cycle: drive inputs, clock edge, advance model, compare all outputs.
    task automatic cyc(input bit ss, input bit clr, input bit upv, input bit rstv);
        logic [3:0] ea;
        btnStartStop = ss;
        btnClear     = clr;
        up           = upv;
        rst_n        = rstv;
        @(posedge clkFPGA);
        model_edge(ss, clr, upv, rstv);
        #1;
        ea = ~(4'b0001 << m_sidx);
        chk("m_digits",  digits,        to_bcd(m_count));
        chk("m_running", 16'(running),  16'(m_state == 1));
        chk("m_tick",    16'(tick),     16'(m_tick));
        chk("m_carry",   16'(carry),    16'(m_carry));
        chk("m_an",      16'(an),       16'(ea));
        chk("m_bcdOut",  16'(bcdOut),   16'((m_count / pw10[m_sidx]) % 10));
    endtask

    // Run without buttons until the model steps; a missed step within the budget is a failure.
    task automatic run_until_tick(input bit upv);
        bit got;
        got = 1'b0;
        for (int k = 0; k < 4 * TD && !got; k++) begin
            cyc(1'b0, 1'b0, upv, 1'b1);
            got = m_tick;
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL step_timeout: actual=no step required=step at %0t", $time);
        end
    endtask

    initial begin
        int         guard;
        int         hold_cnt;
        logic [3:0] exp_b;

        pw10[0] = 1; pw10[1] = 10; pw10[2] = 100; pw10[3] = 1000;

        //             rst   ss    clr   up    digits    run   tick  carry an
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 4'b1110};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 4'b1110};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 4'b1110};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 4'b1110};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 4'b1101};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 4'b1101};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b1, 1'b0, 4'b1101};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b0, 4'b1011};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b0, 4'b1011};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b0, 4'b1011};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b1, 1'b0, 4'b0111};

        // Reset and start from the vector table.
        for (int i = 0; i < 11; i++) begin
            cyc(tbl[i].ss, tbl[i].clr, tbl[i].upd, tbl[i].rst);
            chk("tbl_digits",  digits,       tbl[i].d);
            chk("tbl_running", 16'(running), 16'(tbl[i].run));
            chk("tbl_tick",    16'(tick),    16'(tbl[i].tk));
            chk("tbl_carry",   16'(carry),   16'(tbl[i].cy));
            chk("tbl_an",      16'(an),      16'(tbl[i].an_e));
        end

        // Internal carry 0099 -> 0100.
        guard = 0;
        while (m_count != 99 && guard < 200) begin
            run_until_tick(1'b1);
            guard++;
        end
        run_until_tick(1'b1);
        chk("carry0099_digits", digits,     16'h0100);
        chk("carry0099_carry",  16'(carry), 16'h0000);

        // Internal borrow 0010 -> 0009.
        guard = 0;
        while (m_count != 10 && guard < 200) begin
            run_until_tick(1'b0);
            guard++;
        end
        run_until_tick(1'b0);
        chk("borrow0010_digits", digits, 16'h0009);

        // Down wrap 0000 -> 9999, then up wrap 9999 -> 0000.
        cyc(1'b0, 1'b1, 1'b0, 1'b1);
        chk("clear_digits",  digits,       16'h0000);
        chk("clear_running", 16'(running), 16'h0000);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        run_until_tick(1'b0);
        chk("downwrap_digits", digits,     16'h9999);
        chk("downwrap_carry",  16'(carry), 16'h0001);
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        chk("carry_one_cycle", 16'(carry), 16'h0000);
        run_until_tick(1'b1);
        chk("upwrap_digits", digits,     16'h0000);
        chk("upwrap_carry",  16'(carry), 16'h0001);
        chk("upwrap_tick",   16'(tick),  16'h0001);

        // Pause with the prescaler frozen at 2, hold 20 cycles, then resume.
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 1'b1);
        chk("pause_running", 16'(running), 16'h0000);
        hold_cnt = m_count;
        for (int i = 0; i < 20; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 1'b1);
            chk("pause_digits", digits,    to_bcd(hold_cnt));
            chk("pause_tick",   16'(tick), 16'h0000);
        end
        cyc(1'b1, 1'b0, 1'b1, 1'b1);
        chk("resume_running", 16'(running), 16'h0001);
        chk("resume_tick0",   16'(tick),    16'h0000);
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        chk("resume_tick1", 16'(tick), 16'h0000);
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        chk("resume_step_tick",   16'(tick), 16'h0001);
        chk("resume_step_digits", digits,    to_bcd(hold_cnt + 1));

        // Start/stop on the terminal cycle: the step still lands, FSM pauses.
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 1'b1);
        chk("ss_term_tick",    16'(tick),    16'h0001);
        chk("ss_term_digits",  digits,       to_bcd(hold_cnt + 2));
        chk("ss_term_running", 16'(running), 16'h0000);
        cyc(1'b1, 1'b0, 1'b1, 1'b1);

        // Clear and start/stop together on a terminal cycle.
        guard = 0;
        while (m_presc != TD - 1 && guard < 10) begin
            cyc(1'b0, 1'b0, 1'b1, 1'b1);
            guard++;
        end
        cyc(1'b1, 1'b1, 1'b1, 1'b1);
        chk("clrprio_digits",  digits,       16'h0000);
        chk("clrprio_running", 16'(running), 16'h0000);
        chk("clrprio_tick",    16'(tick),    16'h0000);
        chk("clrprio_carry",   16'(carry),   16'h0000);
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        chk("idle_stays", 16'(running), 16'h0000);

        // Scan of 1234 held in PAUSE.
        cyc(1'b1, 1'b0, 1'b1, 1'b1);
        guard = 0;
        while (m_count != 1234 && guard < 2000) begin
            run_until_tick(1'b1);
            guard++;
        end
        cyc(1'b1, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 24; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 1'b1);
            case (an)
                4'b1110: exp_b = 4'd4;
                4'b1101: exp_b = 4'd3;
                4'b1011: exp_b = 4'd2;
                4'b0111: exp_b = 4'd1;
                default: exp_b = 4'hF;
            endcase
            chk("scan_bcd", 16'(bcdOut), 16'(exp_b));
        end

        // Randomized buttons, direction and occasional reset.
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 19) == 0, $urandom_range(0, 99) == 0,
                1'($urandom_range(0, 1)), $urandom_range(0, 299) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
